// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
//
// Microprogram sequencer that sits directly in front of the microcode ROM.
// It owns the micro-PC (reg_out) and selects the next micro-address every
// cycle. The inputs to that choice are:
//   - the ROM's branch fields (BT, condition, jump_addr);
//   - the datapath status flags;
//   - an internal loop counter used for row/column iteration.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : pulse, launches the microprogram at address 0
//   halt       : halt field of the current microword
//   stall      : hold the current micro-address (memory/core wait)
//   condition  : branch-condition select (00 always, 01 zero flag,
//                10 loop counter non-zero, 11 external ready)
//   BT         : 1 = the current microword is a conditional branch
//   jump_addr  : branch target from the ROM
//   z_flag     : datapath zero flag
//   ext_flag   : external ready flag
//   cnt_load   : load the loop counter with cnt_val
//   cnt_val    : loop counter load value
//   reg_out    : micro-PC, drives the ROM address
//   busy       : high while running
//   done       : high once the microprogram has finished
//   cnt_zero   : loop counter equals zero
//   addr_err   : sticky flag, set by a fetch past MAX_ADDR
// ---------------------------------------------------------------------------
module micro_sequencer #(
  parameter int AW       = 16,
  parameter int JW       = 7,
  parameter int CW       = 8,
  parameter int MAX_ADDR = 127
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  input  logic          stall,
  input  logic [1:0]    condition,
  input  logic          BT,
  input  logic [JW-1:0] jump_addr,
  input  logic          z_flag,
  input  logic          ext_flag,
  input  logic          cnt_load,
  input  logic [CW-1:0] cnt_val,
  output logic [AW-1:0] reg_out,
  output logic          busy,
  output logic          done,
  output logic          cnt_zero,
  output logic          addr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] MAX_PC = AW'(MAX_ADDR);

  state_t        state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;

  logic          branch_test;
  logic [AW-1:0] jump_ext;

  assign jump_ext = AW'(jump_addr);

  // Branch condition multiplexer; only meaningful when BT is set.
  always_comb begin
    branch_test = 1'b0;
    case (condition)
      2'b00:   branch_test = 1'b1;
      2'b01:   branch_test = z_flag;
      2'b10:   branch_test = (cnt_reg != '0);
      default: branch_test = ext_flag;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;

    case (state_reg)
      IDLE: begin
        pc_next = '0;
        if (start) begin
          state_next = RUN;
          err_next   = 1'b0;
        end
      end

      RUN: begin
        if (halt) begin
          // halt outranks stall: finish with the address frozen
          state_next = DONE;
        end else if (stall) begin
          pc_next = pc_reg;
        end else begin
          if (BT && branch_test) begin
            // Targets beyond the legal range are handled like an overrun.
            // This can only happen when JW is widened past 7 bits.
            if (jump_ext > MAX_PC) begin
              pc_next    = '0;
              err_next   = 1'b1;
              state_next = DONE;
            end else begin
              pc_next = jump_ext;
            end
          end else if (pc_reg >= MAX_PC) begin
            // sequential fetch would leave the ROM: wrap, flag, stop
            pc_next    = '0;
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            pc_next = pc_reg + AW'(1);
          end

          // A loop branch consumes one count on the edge it is taken, so
          // a body loaded with N runs N+1 times. The counter never wraps.
          if (BT && (condition == 2'b10) && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
      end

      DONE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = '0;
          err_next   = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        pc_next    = '0;
      end
    endcase

    // an explicit load wins over any decrement, in every state
    if (cnt_load) begin
      cnt_next = cnt_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  assign reg_out  = pc_reg;
  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign cnt_zero = (cnt_reg == '0);
  assign addr_err = err_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer
//
// Directed testbench for micro_sequencer. Inputs are driven 1 time unit
// after each rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        stall;
  logic [1:0]  condition;
  logic        BT;
  logic [6:0]  jump_addr;
  logic        z_flag;
  logic        ext_flag;
  logic        cnt_load;
  logic [7:0]  cnt_val;
  logic [15:0] reg_out;
  logic        busy;
  logic        done;
  logic        cnt_zero;
  logic        addr_err;

  int checks_cnt;
  int errors_cnt;

  micro_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .halt      (halt),
    .stall     (stall),
    .condition (condition),
    .BT        (BT),
    .jump_addr (jump_addr),
    .z_flag    (z_flag),
    .ext_flag  (ext_flag),
    .cnt_load  (cnt_load),
    .cnt_val   (cnt_val),
    .reg_out   (reg_out),
    .busy      (busy),
    .done      (done),
    .cnt_zero  (cnt_zero),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    halt      = 1'b0;
    stall     = 1'b0;
    condition = 2'b00;
    BT        = 1'b0;
    jump_addr = '0;
    z_flag    = 1'b0;
    ext_flag  = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
  endtask

  task automatic branch(input logic [1:0] c, input logic [6:0] tgt);
    BT        = 1'b1;
    condition = c;
    jump_addr = tgt;
  endtask

  // expected micro-PC after each edge of the loop test, starting from 8
  // with the counter loaded to 3
  int loop_pc[12] = '{9, 10, 8, 9, 10, 8, 9, 10, 8, 9, 10, 11};
  int loop_cz[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    int cur_pc;
    int visits10;
    checks_cnt = 0;
    errors_cnt = 0;
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst reg_out", reg_out, 0);
    check_val("rst busy", busy, 0);
    check_val("rst done", done, 0);
    check_val("rst cnt_zero", cnt_zero, 1);
    check_val("rst addr_err", addr_err, 0);

    step();
    rst_n = 1'b1;
    step();
    check_val("idle reg_out", reg_out, 0);
    check_val("idle busy", busy, 0);

    // start: RUN with first fetch at 0, then sequential
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("start busy", busy, 1);
    check_val("start reg_out", reg_out, 0);
    step();
    check_val("seq reg_out", reg_out, 1);
    step();
    check_val("seq reg_out", reg_out, 2);
    start = 1'b1;  // ignored in RUN
    step();
    start = 1'b0;
    check_val("start-in-run reg_out", reg_out, 3);
    check_val("start-in-run busy", busy, 1);
    step();
    step();
    check_val("seq reg_out", reg_out, 5);

    // unconditional branch and z_flag branches
    branch(2'b00, 7'd20);
    step();
    check_val("jmp uncond", reg_out, 20);
    branch(2'b00, 7'd5);
    step();
    check_val("jmp back", reg_out, 5);
    branch(2'b01, 7'd20);
    z_flag = 1'b0;
    step();
    check_val("jmp z=0 falls", reg_out, 6);
    branch(2'b01, 7'd30);
    z_flag = 1'b1;
    step();
    check_val("jmp z=1 taken", reg_out, 30);
    z_flag = 1'b0;
    branch(2'b11, 7'd60);
    ext_flag = 1'b0;
    step();
    check_val("jmp ext=0 falls", reg_out, 31);
    branch(2'b11, 7'd60);
    ext_flag = 1'b1;
    step();
    check_val("jmp ext=1 taken", reg_out, 60);
    ext_flag = 1'b0;

    // loop: jump to 8 while loading 3; microword 10 loops back to 8
    branch(2'b00, 7'd8);
    cnt_load = 1'b1;
    cnt_val  = 8'd3;
    step();
    cnt_load = 1'b0;
    check_val("loop entry", reg_out, 8);
    check_val("loop cnt_zero", cnt_zero, 0);
    cur_pc   = 8;
    visits10 = 0;
    for (int i = 0; i < 12; i++) begin
      if (cur_pc == 10) branch(2'b10, 7'd8);
      else begin
        BT        = 1'b0;
        condition = 2'b00;
      end
      step();
      check_val($sformatf("loop pc[%0d]", i), reg_out, loop_pc[i]);
      check_val($sformatf("loop cz[%0d]", i), cnt_zero, loop_cz[i]);
      if (reg_out == 16'd10) visits10++;
      cur_pc = loop_pc[i];
    end
    check_val("loop visits of 10", visits10, 4);

    // stall at 4 with a pending loop branch: no move, no decrement
    branch(2'b00, 7'd4);
    cnt_load = 1'b1;
    cnt_val  = 8'd1;
    step();
    cnt_load = 1'b0;
    check_val("to 4", reg_out, 4);
    branch(2'b10, 7'd50);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("stall pc[%0d]", i), reg_out, 4);
      check_val($sformatf("stall cz[%0d]", i), cnt_zero, 0);
    end
    halt = 1'b1;  // halt beats stall
    step();
    check_val("halt done", done, 1);
    check_val("halt busy", busy, 0);
    check_val("halt reg_out", reg_out, 4);
    idle_inputs();
    step();
    check_val("done frozen", reg_out, 4);
    check_val("done cz kept", cnt_zero, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("restart reg_out", reg_out, 0);
    check_val("restart busy", busy, 1);
    // the counter still holds 1: this branch is taken and uses it up
    branch(2'b10, 7'd50);
    step();
    check_val("cnt branch taken", reg_out, 50);
    check_val("cnt now zero", cnt_zero, 1);

    // sequential fetch past the top of the ROM
    branch(2'b00, 7'd127);
    step();
    check_val("at 127", reg_out, 127);
    BT = 1'b0;
    step();
    check_val("overrun reg_out", reg_out, 0);
    check_val("overrun addr_err", addr_err, 1);
    check_val("overrun done", done, 1);
    step();
    check_val("addr_err sticky", addr_err, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("err cleared", addr_err, 0);
    check_val("err restart busy", busy, 1);

    // asynchronous reset mid-RUN
    branch(2'b00, 7'd37);
    step();
    check_val("at 37", reg_out, 37);
    idle_inputs();
    #3 rst_n = 1'b0;
    #1;
    check_val("async rst reg_out", reg_out, 0);
    check_val("async rst busy", busy, 0);
    check_val("async rst done", done, 0);
    step();
    rst_n = 1'b1;
    step();
    check_val("post rst idle", reg_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer directly upstream of the microcode ROM: owns the micro-PC and drives the ROM address `reg_out[15:0]`.
- Consumes the ROM's `condition`, `BT` and `jump_addr` fields, plus datapath status, to pick the next micro-address each cycle.
- Holds an internal loop counter for matrix-row/column iteration.
- Provides start/halt/stall control toward the top-level controller.

Parameters:
- AW, 16, width of micro-PC / ROM address.
- JW, 7, width of `jump_addr` field.
- CW, 8, width of loop counter.
- MAX_ADDR, 127, highest legal micro-address.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begin microprogram at address 0.
- halt  input  1  halt field of current microword (from OPs).
- stall  input  1  hold current micro-address (memory/core wait).
- condition  input  2  branch-condition select from ROM.
- BT  input  1  branch-type bit from ROM: 1 = conditional branch microword.
- jump_addr  input  JW  branch target from ROM.
- z_flag  input  1  datapath zero flag.
- ext_flag  input  1  external ready flag (cores done).
- cnt_load  input  1  load loop counter.
- cnt_val  input  CW  loop counter load value.
- reg_out  output  AW  micro-PC, feeds ROM address.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- cnt_zero  output  1  loop counter == 0.
- addr_err  output  1  sticky: sequential fetch past MAX_ADDR.

Behaviour:
Reset and state machine:
- Reset (async, `rst_n`=0):
  - state=IDLE, `reg_out`=0, loop counter=0.
  - `busy`=0, `done`=0, `addr_err`=0; `cnt_zero`=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `reg_out` held 0. `start`=1 -> RUN next cycle, `reg_out` stays 0, so the first microword fetched is address 0.
  - RUN: `busy`=1. `reg_out` updates every rising edge per next-address rule.
  - DONE: `done`=1, `reg_out` frozen. `start`=1 -> RUN with `reg_out`=0 and `addr_err` cleared.
  - `start` in RUN is ignored.

Next-address rule (RUN only):
- ROM is combinational: `condition`, `BT` and `jump_addr` are valid in the same cycle as `reg_out`.
- Priority: `halt` > `stall` > branch > increment.
  - `halt`=1: next state DONE, `reg_out` holds.
  - `stall`=1: `reg_out` holds; loop counter does not decrement.
  - `BT`=1: test = select(`condition`):
    - 00: 1 (unconditional)
    - 01: `z_flag`
    - 10: loop counter != 0
    - 11: `ext_flag`
  - test=1: `reg_out` <= zero-extended `jump_addr`. test=0: `reg_out` <= `reg_out`+1.
  - `BT`=0: `reg_out` <= `reg_out`+1.
- Increment from MAX_ADDR: `reg_out` <= 0, `addr_err` <= 1 (sticky), state -> DONE.
- Branch target > MAX_ADDR is impossible with defaults (JW=7); if JW > 7, the same error rule applies.

Loop counter:
- `cnt_load`=1: counter <= `cnt_val` (any state). Load overrides decrement.
- Decrement: in RUN, when `BT`=1, `condition`=10, counter != 0 and `stall`=0, counter decrements by 1 on the same edge the branch is taken.
  - Result: a loop body executes N+1 times for load value N.
- Counter = 0: no decrement, no wrap; branch falls through.
- `cnt_zero` is combinational from the counter register.

Other rules:
- No latency beyond one cycle: the next address is registered on the edge following microword presentation.
- Reset mid-RUN: immediate return to reset values regardless of `stall`/`halt`.
- `stall` and `halt` together: `halt` wins.

Test Plan:
- Reset then `start` pulse, `BT`=0, no `stall` -> `reg_out` 0,1,2,3 on successive edges; `busy`=1.
- At `reg_out`=5: `BT`=1, `condition`=00, `jump_addr`=20 -> `reg_out`=20 next edge. Same with `condition`=01, `z_flag`=0 -> `reg_out`=6.
- `cnt_load` `cnt_val`=3; microword at 10 is `BT`=1, `condition`=10, `jump_addr`=8, with 8,9 sequential -> 10 is visited 4 times, then `reg_out`=11; `cnt_zero`=1 after the third taken branch.
- `stall` high 3 cycles at `reg_out`=4 -> `reg_out` stays 4, counter unchanged; `stall` and `halt` together -> DONE, `done`=1, `reg_out`=4 held; `start` -> `reg_out`=0, RUN.
- Sequential fetch at `reg_out`=127 -> `reg_out`=0, `addr_err`=1, DONE.
- `rst_n` low asynchronously mid-RUN at `reg_out`=37 -> `reg_out`=0, IDLE, `busy`=0 before the next clock edge.
